mem_port_arbiter: RTL and testbench

Shares the single 16-bit word-addressed program/data memory between the instruction-fetch unit and the load/store unit of the processor. Each requester issues a held request with a registered grant, a fixed-latency access and a one-cycle acknowledge. The block sits between the pipeline front-end/memory stage and the memory array, which has a combinational read port and a synchronous write port. Data accesses have priority, and a starvation counter guarantees fetch forward progress.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Fetch, load/store and memory-side signals of the shared memory port
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_we, mem_wdata
    );

    // Requesters and memory array side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_we, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Data-priority arbiter for the shared program/data memory port
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner;      // 1 = load/store unit, 0 = fetch unit
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [CNT_W-1:0]  starve_cnt;

    logic starved;
    logic grant_d;
    logic grant_if;

    always_comb begin
        starved  = bus.if_req && (starve_cnt == CNT_MAX);
        grant_d  = bus.d_req && !starved;
        grant_if = bus.if_req && !grant_d;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_d || grant_if) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            starve_cnt <= '0;
        end else begin
            if (state == IDLE) begin
                if (grant_d) begin
                    owner   <= 1'b1;
                    we_q    <= bus.d_we;
                    addr_q  <= bus.d_addr;
                    wdata_q <= bus.d_wdata;
                end else if (grant_if) begin
                    owner  <= 1'b0;
                    we_q   <= 1'b0;
                    addr_q <= bus.if_addr;
                end
                // Only data wins taken against a waiting fetch count toward starvation
                if (!bus.if_req || grant_if) begin
                    starve_cnt <= '0;
                end else if (grant_d && (starve_cnt != CNT_MAX)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
            if ((state == ACCESS) && !(owner && we_q)) begin
                if (owner) begin
                    d_rdata_q <= bus.mem_rdata;
                end else begin
                    if_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    // Decoded from state so that an asynchronous reset clears them at once
    assign bus.mem_we    = (state == ACCESS) && owner && we_q;
    assign bus.if_ack    = (state == RESP) && !owner;
    assign bus.d_ack     = (state == RESP) && owner;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed vector table plus multi-cycle sequences for the arbiter
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(
        .ADDR_W(16),
        .DATA_W(16),
        .STARVE_MAX(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic [15:0] mem [0:65535];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    typedef struct {
        logic        if_req;
        logic [15:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic        e_if_ack;
        logic        e_d_ack;
        logic        e_mem_we;
        logic [15:0] e_mem_addr;
        logic [15:0] e_if_rdata;
        logic [15:0] e_d_rdata;
    } vec_t;

    vec_t vecs [15];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] order;
        int         acks;
        int         cyc;

        mem[16'h0010] <= 16'hABCD;
        mem[16'h0020] <= 16'h0000;
        mem[16'h0030] <= 16'h0000;
        mem[16'h0042] <= 16'hBEEF;

        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // if_req, if_addr, d_req, d_we, d_addr, d_wdata | if_ack, d_ack, mem_we, mem_addr, if_rdata, d_rdata
        vecs[0]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hABCD, 16'h0000};
        vecs[2]  = '{1'b0, 16'h0010, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hABCD, 16'h0000};
        vecs[3]  = '{1'b0, 16'h0010, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h0020, 16'hABCD, 16'h0000};
        vecs[4]  = '{1'b0, 16'h0010, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0020, 16'hABCD, 16'h0000};
        vecs[5]  = '{1'b0, 16'h0010, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0020, 16'hABCD, 16'h0000};
        vecs[6]  = '{1'b0, 16'h0010, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0020, 16'hABCD, 16'h0000};
        vecs[7]  = '{1'b0, 16'h0010, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0020, 16'hABCD, 16'h1234};
        vecs[8]  = '{1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0020, 16'hABCD, 16'h1234};
        vecs[9]  = '{1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0020, 16'hABCD, 16'h1234};
        vecs[10] = '{1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0020, 16'hABCD, 16'h1234};
        vecs[11] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0020, 16'hABCD, 16'h1234};
        vecs[12] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hABCD, 16'h1234};
        vecs[13] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hABCD, 16'h1234};
        vecs[14] = '{1'b0, 16'h0010, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hABCD, 16'h1234};

        repeat (2) @(negedge clk);
        chk("reset if_ack",    bus.if_ack,     0);
        chk("reset d_ack",     bus.d_ack,      0);
        chk("reset mem_we",    bus.mem_we,     0);
        chk("reset mem_addr",  bus.mem_addr,   0);
        chk("reset mem_wdata", bus.mem_wdata,  0);
        chk("reset if_rdata",  bus.if_rdata,   0);
        chk("reset d_rdata",   bus.d_rdata,    0);
        chk("reset starve",    dut.starve_cnt, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            bus.if_req  = vecs[i].if_req;
            bus.if_addr = vecs[i].if_addr;
            bus.d_req   = vecs[i].d_req;
            bus.d_we    = vecs[i].d_we;
            bus.d_addr  = vecs[i].d_addr;
            bus.d_wdata = vecs[i].d_wdata;
            step();
            chk($sformatf("v%0d if_ack", i),   bus.if_ack,   vecs[i].e_if_ack);
            chk($sformatf("v%0d d_ack", i),    bus.d_ack,    vecs[i].e_d_ack);
            chk($sformatf("v%0d mem_we", i),   bus.mem_we,   vecs[i].e_mem_we);
            chk($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].e_mem_addr);
            chk($sformatf("v%0d if_rdata", i), bus.if_rdata, vecs[i].e_if_rdata);
            chk($sformatf("v%0d d_rdata", i),  bus.d_rdata,  vecs[i].e_d_rdata);
        end

        // Starvation guard: fetch held against back-to-back loads; 1 marks a fetch grant
        bus.if_req = 1'b1; bus.if_addr = 16'h0010;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0100;
        order = '0; acks = 0; cyc = 0;
        while (acks < 5 && cyc < 60) begin
            step();
            cyc++;
            if (bus.d_ack) begin
                order = {order[3:0], 1'b0};
                acks++;
                bus.d_addr = bus.d_addr + 16'h0001;
            end
            if (bus.if_ack) begin
                order = {order[3:0], 1'b1};
                acks++;
                chk("starve_cnt after fetch grant", dut.starve_cnt, 0);
                bus.if_req = 1'b0;
            end
            if (acks >= 5) begin
                bus.d_req = 1'b0;
                bus.if_req = 1'b0;
            end
        end
        chk("starve ack count", acks, 5);
        chk("starve grant order", order, 5'b00010);
        step();

        // Reset asserted during a store's ACCESS cycle
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0030; bus.d_wdata = 16'h5555;
        step();
        chk("rst pre mem_we", bus.mem_we, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst mem_we",    bus.mem_we,    0);
        chk("rst d_ack",     bus.d_ack,     0);
        chk("rst if_ack",    bus.if_ack,    0);
        chk("rst mem_addr",  bus.mem_addr,  0);
        chk("rst mem_wdata", bus.mem_wdata, 0);
        chk("rst if_rdata",  bus.if_rdata,  0);
        chk("rst d_rdata",   bus.d_rdata,   0);
        @(posedge clk);
        @(negedge clk);
        chk("rst held d_ack", bus.d_ack, 0);
        chk("rst no write",   mem[16'h0030], 16'h0000);
        rst_n = 1'b1;
        step();
        chk("rerun mem_we",    bus.mem_we,    1);
        chk("rerun d_ack+1",   bus.d_ack,     0);
        chk("rerun mem_addr",  bus.mem_addr,  16'h0030);
        chk("rerun mem_wdata", bus.mem_wdata, 16'h5555);
        step();
        chk("rerun d_ack+2", bus.d_ack,     1);
        chk("rerun write",   mem[16'h0030], 16'h5555);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        step();

        // Idle hold after a fetch from 0x0042
        bus.if_req = 1'b1; bus.if_addr = 16'h0042;
        step();
        step();
        chk("hold fetch ack",   bus.if_ack,   1);
        chk("hold fetch rdata", bus.if_rdata, 16'hBEEF);
        bus.if_req = 1'b0;
        step();
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("hold%0d mem_addr", k), bus.mem_addr, 16'h0042);
            chk($sformatf("hold%0d mem_we", k),   bus.mem_we,   0);
            chk($sformatf("hold%0d if_ack", k),   bus.if_ack,   0);
            chk($sformatf("hold%0d d_ack", k),    bus.d_ack,    0);
            chk($sformatf("hold%0d if_rdata", k), bus.if_rdata, 16'hBEEF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
